// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: connects NUM_PORTS cache ports to one physical memory port.
// The arbiter serves one transaction at a time. The winner's address, write
// line and direction are latched when it is granted, so the memory request
// stays stable while that transaction is in flight. A one-cycle TURN gap
// follows every completed transaction before the next arbitration.
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int RR_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]   port_wdata,
  input  logic [NUM_PORTS-1:0]          port_read,
  input  logic [NUM_PORTS-1:0]          port_write,
  output logic [LINE_W-1:0]             port_rdata,
  output logic [NUM_PORTS-1:0]          port_resp,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic [LINE_W-1:0]             mem_rdata,
  input  logic                          mem_resp,
  output logic [NUM_PORTS-1:0]          grant
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  // Registered state
  state_t                state_reg;
  logic [PTR_W-1:0]      ptr_reg;
  logic [NUM_PORTS-1:0]  grant_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [LINE_W-1:0]     wdata_reg;
  logic                  read_reg;
  logic                  write_reg;

  // Arbitration signals
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  rot_req;
  logic [PTR_W-1:0]      eff_ptr;
  logic [PTR_W-1:0]      rot_off;
  logic [PTR_W:0]        sum_idx;
  logic [PTR_W-1:0]      win_idx;
  logic [NUM_PORTS-1:0]  win_onehot;
  logic                  win_valid;
  logic [PTR_W-1:0]      next_ptr;

  // Winner's captured request fields
  logic [ADDR_W-1:0]     sel_addr;
  logic [LINE_W-1:0]     sel_wdata;
  logic                  sel_read;
  logic                  sel_write;

  logic                  resp_fire;

  // Per-port views of the flattened address / write-line buses
  logic [ADDR_W-1:0]     addr_arr  [NUM_PORTS];
  logic [LINE_W-1:0]     wdata_arr [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = port_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = port_wdata[gi*LINE_W +: LINE_W];
      assign req[gi]       = port_read[gi] | port_write[gi];
    end
  endgenerate

  // Fixed priority behaves like round-robin with the pointer pinned at port 0
  assign eff_ptr = (RR_MODE != 0) ? ptr_reg : '0;

  // Rotate requests so that the port at the pointer sits at bit 0, find the
  // first requester in rotated order, then map it back to a physical port
  always_comb begin
    rot_req   = NUM_PORTS'({req, req} >> eff_ptr);
    rot_off   = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (rot_req[j]) begin
        rot_off = PTR_W'(j);
      end
    end
    sum_idx = {1'b0, eff_ptr} + {1'b0, rot_off};
    if (sum_idx >= (PTR_W+1)'(NUM_PORTS)) begin
      sum_idx = sum_idx - (PTR_W+1)'(NUM_PORTS);
    end
    win_idx    = sum_idx[PTR_W-1:0];
    win_valid  = |req;
    win_onehot = NUM_PORTS'(1) << win_idx;
    if (win_idx == PTR_W'(NUM_PORTS - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = win_idx + PTR_W'(1);
    end
  end

  // Mux out the winner's request; a simultaneous write overrides the read
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (win_onehot[j]) begin
        sel_addr  = addr_arr[j];
        sel_wdata = wdata_arr[j];
        sel_write = port_write[j];
        sel_read  = port_read[j] & ~port_write[j];
      end
    end
  end

  // Arbitration FSM with registered memory request and grant outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg <= BUSY;
            grant_reg <= win_onehot;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            read_reg  <= sel_read;
            write_reg <= sel_write;
            ptr_reg   <= next_ptr;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            state_reg <= TURN;
            grant_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
          end
        end
        TURN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          read_reg  <= 1'b0;
          write_reg <= 1'b0;
        end
      endcase
    end
  end

  // Memory-side outputs come only from the latched copies
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_read  = read_reg;
  assign mem_write = write_reg;
  assign grant     = grant_reg;

  // The completion pulse and read line are passed through in the reply cycle
  assign resp_fire  = (state_reg == BUSY) && mem_resp;
  assign port_resp  = resp_fire ? grant_reg : '0;
  assign port_rdata = resp_fire ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: three arbiter instances (2-port round-robin, 4-port fixed
// priority, 4-port round-robin) checked every cycle against a transaction-level
// model, plus directed literal expectations for the key scenarios.
module tb_mem_arbiter_rr;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int MAXP = 4;
  localparam int NSLOT = 6;

  localparam int F_GRANT = 0;
  localparam int F_RESP  = 1;
  localparam int F_RDATA = 2;
  localparam int F_RD    = 3;
  localparam int F_WR    = 4;
  localparam int F_ADDR  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus, one entry per instance (0: N2 RR, 1: N4 fixed, 2: N4 RR)
  logic [MAXP-1:0]    rd_i     [3];
  logic [MAXP-1:0]    wr_i     [3];
  logic [MAXP*AW-1:0] addr_i   [3];
  logic [MAXP*LW-1:0] wdata_i  [3];
  logic               mresp_i  [3];
  logic [LW-1:0]      mrdata_i [3];

  // Per-instance raw outputs
  logic [1:0] grant_a, resp_a;
  logic [3:0] grant_b, resp_b, grant_c, resp_c;
  logic [LW-1:0] rdata_a, rdata_b, rdata_c, mwdata_a, mwdata_b, mwdata_c;
  logic [AW-1:0] maddr_a, maddr_b, maddr_c;
  logic mrd_a, mrd_b, mrd_c, mwr_a, mwr_b, mwr_c;

  // Gathered outputs
  logic [MAXP-1:0] grant_o  [3];
  logic [MAXP-1:0] resp_o   [3];
  logic [LW-1:0]   rdata_o  [3];
  logic [LW-1:0]   mwdata_o [3];
  logic [AW-1:0]   maddr_o  [3];
  logic            mrd_o    [3];
  logic            mwr_o    [3];

  assign grant_o[0] = {2'b00, grant_a};
  assign grant_o[1] = grant_b;
  assign grant_o[2] = grant_c;
  assign resp_o[0]  = {2'b00, resp_a};
  assign resp_o[1]  = resp_b;
  assign resp_o[2]  = resp_c;
  assign rdata_o[0] = rdata_a;
  assign rdata_o[1] = rdata_b;
  assign rdata_o[2] = rdata_c;
  assign mwdata_o[0] = mwdata_a;
  assign mwdata_o[1] = mwdata_b;
  assign mwdata_o[2] = mwdata_c;
  assign maddr_o[0] = maddr_a;
  assign maddr_o[1] = maddr_b;
  assign maddr_o[2] = maddr_c;
  assign mrd_o[0] = mrd_a;
  assign mrd_o[1] = mrd_b;
  assign mrd_o[2] = mrd_c;
  assign mwr_o[0] = mwr_a;
  assign mwr_o[1] = mwr_b;
  assign mwr_o[2] = mwr_c;

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_a (
    .clk(clk), .rst(rst),
    .port_addr(addr_i[0][2*AW-1:0]), .port_wdata(wdata_i[0][2*LW-1:0]),
    .port_read(rd_i[0][1:0]), .port_write(wr_i[0][1:0]),
    .port_rdata(rdata_a), .port_resp(resp_a),
    .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_read(mrd_a), .mem_write(mwr_a),
    .mem_rdata(mrdata_i[0]), .mem_resp(mresp_i[0]), .grant(grant_a)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_b (
    .clk(clk), .rst(rst),
    .port_addr(addr_i[1]), .port_wdata(wdata_i[1]),
    .port_read(rd_i[1]), .port_write(wr_i[1]),
    .port_rdata(rdata_b), .port_resp(resp_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_read(mrd_b), .mem_write(mwr_b),
    .mem_rdata(mrdata_i[1]), .mem_resp(mresp_i[1]), .grant(grant_b)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_c (
    .clk(clk), .rst(rst),
    .port_addr(addr_i[2]), .port_wdata(wdata_i[2]),
    .port_read(rd_i[2]), .port_write(wr_i[2]),
    .port_rdata(rdata_c), .port_resp(resp_c),
    .mem_addr(maddr_c), .mem_wdata(mwdata_c), .mem_read(mrd_c), .mem_write(mwr_c),
    .mem_rdata(mrdata_i[2]), .mem_resp(mresp_i[2]), .grant(grant_c)
  );

  function automatic int nports(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic bit rrmode(input int k);
    return (k != 1);
  endfunction

  // Transaction-level model: phase 0 waiting, 1 serving owner, 2 gap cycle
  int            m_phase [3];
  int            m_owner [3];
  int            m_ptr   [3];
  logic [AW-1:0] m_addr  [3];
  logic [LW-1:0] m_wdata [3];
  bit            m_wr    [3];

  always @(posedge clk or negedge rst) begin : model
    int pick;
    int p;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_phase[k] <= 0;
        m_owner[k] <= 0;
        m_ptr[k]   <= 0;
        m_addr[k]  <= '0;
        m_wdata[k] <= '0;
        m_wr[k]    <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_phase[k] == 0) begin
          pick = -1;
          for (int s = 0; s < nports(k); s++) begin
            p = rrmode(k) ? (m_ptr[k] + s) % nports(k) : s;
            if (pick < 0 && (rd_i[k][p] || wr_i[k][p])) pick = p;
          end
          if (pick >= 0) begin
            m_phase[k] <= 1;
            m_owner[k] <= pick;
            m_addr[k]  <= addr_i[k][pick*AW +: AW];
            m_wdata[k] <= wdata_i[k][pick*LW +: LW];
            m_wr[k]    <= wr_i[k][pick];
            m_ptr[k]   <= (pick + 1) % nports(k);
          end
        end else if (m_phase[k] == 1) begin
          if (mresp_i[k]) m_phase[k] <= 2;
        end else begin
          m_phase[k] <= 0;
        end
      end
    end
  end

  // Literal expectation slots, filled by the stimulus and checked at negedge
  bit            lit_en   [NSLOT];
  int            lit_k    [NSLOT];
  int            lit_f    [NSLOT];
  logic [LW-1:0] lit_exp  [NSLOT];
  string         lit_name [NSLOT];

  int total  = 0;
  int passed = 0;

  function automatic logic [LW-1:0] get_sig(input int k, input int f);
    case (f)
      F_GRANT: return LW'(grant_o[k]);
      F_RESP:  return LW'(resp_o[k]);
      F_RDATA: return rdata_o[k];
      F_RD:    return LW'(mrd_o[k]);
      F_WR:    return LW'(mwr_o[k]);
      default: return LW'(maddr_o[k]);
    endcase
  endfunction

  function automatic void chk(input string name, input int k,
                              input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d: actual %0h required %0h", name, k, act, exp);
  endfunction

  // Single compare process: model expectations for every instance each cycle
  always @(negedge clk) begin : compare
    bit busy;
    bit fire;
    logic [MAXP-1:0] e_grant;
    for (int k = 0; k < 3; k++) begin
      busy    = (m_phase[k] == 1);
      fire    = busy && mresp_i[k];
      e_grant = busy ? (4'b0001 << m_owner[k]) : 4'b0000;
      chk("grant", k, LW'(grant_o[k]), LW'(e_grant));
      chk("port_resp", k, LW'(resp_o[k]), fire ? LW'(e_grant) : '0);
      chk("port_rdata", k, rdata_o[k], fire ? mrdata_i[k] : '0);
      chk("mem_read", k, LW'(mrd_o[k]), LW'(busy && !m_wr[k]));
      chk("mem_write", k, LW'(mwr_o[k]), LW'(busy && m_wr[k]));
      chk("mem_addr", k, LW'(maddr_o[k]), busy ? LW'(m_addr[k]) : '0);
      chk("mem_wdata", k, mwdata_o[k], busy ? m_wdata[k] : '0);
    end
    for (int s = 0; s < NSLOT; s++) begin
      if (lit_en[s]) chk(lit_name[s], lit_k[s], get_sig(lit_k[s], lit_f[s]), lit_exp[s]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int s = 0; s < NSLOT; s++) lit_en[s] = 1'b0;
  endtask

  task automatic lit_add(input string name, input int k, input int f, input logic [LW-1:0] exp);
    int s;
    s = 0;
    while (s < NSLOT && lit_en[s]) s++;
    if (s < NSLOT) begin
      lit_en[s]   = 1'b1;
      lit_k[s]    = k;
      lit_f[s]    = f;
      lit_exp[s]  = exp;
      lit_name[s] = name;
    end
  endtask

  task automatic wait_grant(input int k);
    int n;
    n = 0;
    while (grant_o[k] == '0 && n < 30) begin
      cyc();
      n++;
    end
  endtask

  // Wait for a grant, answer after dly cycles, leave the bench in the gap cycle
  task automatic serve(input int k, input int dly, input logic [LW-1:0] data,
                       input logic [MAXP-1:0] exp_grant, input string name);
    wait_grant(k);
    lit_add(name, k, F_GRANT, LW'(exp_grant));
    repeat (dly) cyc();
    mresp_i[k]  = 1'b1;
    mrdata_i[k] = data;
    lit_add("resp_onehot", k, F_RESP, LW'(exp_grant));
    lit_add("resp_rdata", k, F_RDATA, data);
    cyc();
    mresp_i[k]  = 1'b0;
    mrdata_i[k] = '0;
    lit_add("turn_grant", k, F_GRANT, '0);
  endtask

  logic [LW-1:0] ab;
  logic [LW-1:0] ones;

  initial begin
    ab   = {32{8'hAB}};
    ones = '1;
    rst  = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      lit_en[s] = 1'b0; lit_k[s] = 0; lit_f[s] = 0; lit_exp[s] = '0; lit_name[s] = "";
    end
    for (int k = 0; k < 3; k++) begin
      rd_i[k] = '0; wr_i[k] = '0; addr_i[k] = '0; wdata_i[k] = '0;
      mresp_i[k] = 1'b0; mrdata_i[k] = '0;
    end
    cyc();
    lit_add("rst_grant", 0, F_GRANT, '0);
    lit_add("rst_rd", 0, F_RD, '0);
    lit_add("rst_addr", 2, F_ADDR, '0);

    // Both ports of the 2-port instance request across reset exit
    rd_i[0] = 4'b0011;
    addr_i[0][0 +: AW]  = 32'h0000_0010;
    addr_i[0][AW +: AW] = 32'h0000_0020;
    cyc();
    lit_add("rst_hold_grant", 0, F_GRANT, '0);
    rst = 1'b1;
    cyc();
    serve(0, 1, {8{32'h1111_0000}}, 4'b0001, "rr_first_p0");
    serve(0, 1, {8{32'h2222_0000}}, 4'b0010, "rr_second_p1");
    serve(0, 0, {8{32'h3333_0000}}, 4'b0001, "rr_third_p0");
    serve(0, 2, {8{32'h4444_0000}}, 4'b0010, "rr_fourth_p1");
    rd_i[0] = '0;
    cyc(); cyc();

    // Reset while BUSY abandons the transaction
    rd_i[0] = 4'b0001;
    addr_i[0][0 +: AW] = 32'h0000_0040;
    cyc();
    lit_add("pre_rst_grant", 0, F_GRANT, 4'b0001);
    cyc(); cyc();
    rst = 1'b0;
    mresp_i[0]  = 1'b1;
    mrdata_i[0] = ones;
    lit_add("rst_busy_grant", 0, F_GRANT, '0);
    lit_add("rst_busy_rd", 0, F_RD, '0);
    lit_add("rst_busy_addr", 0, F_ADDR, '0);
    lit_add("rst_busy_resp", 0, F_RESP, '0);
    lit_add("rst_busy_rdata", 0, F_RDATA, '0);
    cyc();
    mresp_i[0]  = 1'b0;
    mrdata_i[0] = '0;
    cyc();
    rst = 1'b1;
    lit_add("rel_idle_grant", 0, F_GRANT, '0);
    cyc();
    lit_add("fresh_arb", 0, F_GRANT, 4'b0001);
    serve(0, 0, {8{32'h5555_0000}}, 4'b0001, "fresh_serve");
    rd_i[0] = '0;
    cyc(); cyc();

    // Single read from port 1
    rd_i[0] = 4'b0010;
    addr_i[0][AW +: AW] = 32'h0000_1000;
    lit_add("rd_before_edge", 0, F_RD, '0);
    cyc();
    lit_add("rd_latency", 0, F_RD, 1);
    lit_add("rd_addr", 0, F_ADDR, 32'h0000_1000);
    lit_add("rd_grant", 0, F_GRANT, 4'b0010);
    cyc(); cyc();
    mresp_i[0]  = 1'b1;
    mrdata_i[0] = ab;
    lit_add("rd_resp", 0, F_RESP, 4'b0010);
    lit_add("rd_rdata", 0, F_RDATA, ab);
    cyc();
    mresp_i[0]  = 1'b0;
    mrdata_i[0] = '0;
    rd_i[0] = '0;
    lit_add("rd_turn_grant", 0, F_GRANT, '0);
    lit_add("rd_turn_rd", 0, F_RD, '0);
    cyc(); cyc();

    // Fixed priority: ports 2 and 3 held, port 2 always wins
    wr_i[1] = 4'b1100;
    addr_i[1][2*AW +: AW] = 32'h0000_0200;
    addr_i[1][3*AW +: AW] = 32'h0000_0300;
    wdata_i[1][2*LW +: LW] = {8{32'hC0DE_0002}};
    wdata_i[1][3*LW +: LW] = {8{32'hC0DE_0003}};
    serve(1, 1, '0, 4'b0100, "fixed_p2_a");
    serve(1, 0, '0, 4'b0100, "fixed_p2_b");
    serve(1, 2, '0, 4'b0100, "fixed_p2_c");
    wr_i[1] = '0;
    cyc(); cyc();

    // Round-robin wrap: grant port 2, then ports 0 and 3 compete
    rd_i[2] = 4'b0100;
    addr_i[2][2*AW +: AW] = 32'h0000_2222;
    serve(2, 0, {8{32'h6666_0000}}, 4'b0100, "wrap_pre_p2");
    rd_i[2] = 4'b1001;
    addr_i[2][0 +: AW]    = 32'h0000_0AAA;
    addr_i[2][3*AW +: AW] = 32'h0000_3333;
    serve(2, 1, {8{32'h7777_0000}}, 4'b1000, "wrap_p3_wins");
    rd_i[2] = 4'b0011;
    serve(2, 0, {8{32'h8888_0000}}, 4'b0001, "ptr_zero_p0");
    rd_i[2] = '0;
    cyc(); cyc();

    // A memory reply while idle is ignored
    mresp_i[2]  = 1'b1;
    mrdata_i[2] = ones;
    lit_add("idle_resp", 2, F_RESP, '0);
    lit_add("idle_rdata", 2, F_RDATA, '0);
    cyc();
    mresp_i[2]  = 1'b0;
    mrdata_i[2] = '0;

    // Read+write together, then address churn during BUSY
    rd_i[2] = 4'b0001;
    wr_i[2] = 4'b0001;
    addr_i[2][0 +: AW]  = 32'h0000_0100;
    wdata_i[2][0 +: LW] = {8{32'hFEED_BEEF}};
    cyc();
    lit_add("rw_addr", 2, F_ADDR, 32'h0000_0100);
    lit_add("rw_write", 2, F_WR, 1);
    lit_add("rw_read", 2, F_RD, '0);
    addr_i[2][0 +: AW]  = 32'h0000_0200;
    wdata_i[2][0 +: LW] = '0;
    cyc();
    lit_add("churn_addr", 2, F_ADDR, 32'h0000_0100);
    serve(2, 1, '0, 4'b0001, "churn_serve");
    rd_i[2] = '0;
    wr_i[2] = '0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
